// File: rtl/posit16_pkg.sv
// Shared constants, FSM state type and BCD helper for the posit16 display converter.
// Optional done output is enabled by defining DISPLAY_POSIT16_DONE_EN.
package posit16_pkg;

  localparam int          POSIT_NBITS  = 16;
  localparam int          POSIT_ES     = 1;
  localparam int          MANT_BITS    = 12;
  localparam int          BCD_DIGITS   = 10;
  localparam logic [15:0] NAR_PATTERN  = 16'h8000;

  localparam int          WHOLE_BITS   = 30;
  localparam int          FRAC_BITS    = 40;
  localparam int          FIXED_BITS   = WHOLE_BITS + FRAC_BITS;
  localparam int          DABBLE_STEPS = 30;
  localparam int          FRAC_STEPS   = 10;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  typedef logic signed [4:0] regime_t;

  // Add-3 correction for the lower nine digits; the top digit never reaches 5
  // before the final shift because the whole part stays below 2^30.
  function automatic logic [4*(BCD_DIGITS-1)-1:0] bcd_add3(
    input logic [4*(BCD_DIGITS-1)-1:0] d
  );
    logic [4*(BCD_DIGITS-1)-1:0] r;
    r = d;
    for (int i = 0; i < BCD_DIGITS - 1; i++) begin
      if (d[4*i +: 4] >= 4'd5) r[4*i +: 4] = d[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/decompose_posit.sv
// Combinational field extractor for a 16-bit, es=1 posit: sign, regime k,
// exponent bit and left-aligned mantissa of the magnitude.
module decompose_posit
  import posit16_pkg::*;
(
  output logic                 sign,
  output regime_t              regime,
  output logic                 exponent,
  output logic [MANT_BITS-1:0] mantissa,
  input  logic [POSIT_NBITS-1:0] posit
);

  logic [POSIT_NBITS-2:0] body;
  logic [3:0]             run;
  logic                   in_run;
  logic [MANT_BITS:0]     tail;

  // NOTE: every variable gets a value before any conditional update, so no latch is inferred.
  always_comb begin
    sign   = posit[POSIT_NBITS-1];
    body   = sign ? (~posit[POSIT_NBITS-2:0] + 15'd1) : posit[POSIT_NBITS-2:0];
    run    = 4'd1;
    in_run = 1'b1;
    for (int i = POSIT_NBITS - 3; i >= 0; i--) begin
      if (in_run && (body[i] == body[POSIT_NBITS-2])) run = run + 4'd1;
      else in_run = 1'b0;
    end
    // Drop the run and its terminator: what is left starts with the exponent bit.
    tail     = body[MANT_BITS:0] << (run - 4'd1);
    exponent = tail[MANT_BITS];
    mantissa = tail[MANT_BITS-1:0];
    regime   = body[POSIT_NBITS-2] ? regime_t'(run - 4'd1) : -regime_t'(run);
    if (body == '0) begin
      regime   = '0;
      exponent = 1'b0;
      mantissa = '0;
    end
  end

endmodule

// File: rtl/display_posit16.sv
// Converts a posit16 (es=1) into 10+10 packed BCD digits of its magnitude.
// Define DISPLAY_POSIT16_DONE_EN to add a done output that is high in DONE.
module display_posit16
  import posit16_pkg::*;
#(
  parameter int POSIT_NBITS = posit16_pkg::POSIT_NBITS,
  parameter int POSIT_ES    = posit16_pkg::POSIT_ES,
  parameter int BCD_DIGITS  = posit16_pkg::BCD_DIGITS
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [POSIT_NBITS-1:0]  posit,
  output logic [4*BCD_DIGITS-1:0] whole_bcd,
  output logic [4*BCD_DIGITS-1:0] frac_bcd
`ifdef DISPLAY_POSIT16_DONE_EN
  ,
  output logic                    done
`endif
);

  localparam int W = 4 * BCD_DIGITS;

  logic                   dec_sign;
  regime_t                dec_regime;
  logic                   dec_exp;
  logic [MANT_BITS-1:0]   dec_mant;

  logic                   special;
  logic                   zero_in;
  logic                   nar_in;
  logic [6:0]             shamt;
  logic [FIXED_BITS-1:0]  fixed;

  state_t                 state;
  logic [4:0]             step;
  logic [POSIT_NBITS-1:0] cap;
  logic                   nar_q;
  logic [WHOLE_BITS-1:0]  bin;
  logic [FRAC_BITS-1:0]   frac;
  logic [W-1:0]           bcd_w;
  logic [W-1:0]           bcd_f;

  logic                   start;
  logic [W-1:0]           dabble_next;
  logic [FRAC_BITS+3:0]   frac_prod;

  decompose_posit u_decompose (dec_sign, dec_regime, dec_exp, dec_mant, posit);

  // Fixed point value = (4096 + mantissa) << (2k + e + 28), 30.40 format.
  always_comb begin
    special = (posit[POSIT_NBITS-2:0] == '0);
    zero_in = special & ~dec_sign;
    nar_in  = (posit == NAR_PATTERN);
    shamt   = ({{2{dec_regime[4]}}, dec_regime} << POSIT_ES) + {6'd0, dec_exp} + 7'd28;
    fixed   = zero_in ? '0 : (FIXED_BITS'({1'b1, dec_mant}) << shamt);
  end

  always_comb begin
    start       = (state == IDLE) || ((state == DONE) && (posit != cap));
    dabble_next = {bcd_w[W-2:W-4], bcd_add3(bcd_w[W-5:0]), bin[WHOLE_BITS-1]};
    frac_prod   = ({4'd0, frac} << 3) + ({4'd0, frac} << 1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      step      <= '0;
      cap       <= '0;
      nar_q     <= 1'b0;
      bin       <= '0;
      frac      <= '0;
      bcd_w     <= '0;
      bcd_f     <= '0;
      whole_bcd <= '0;
      frac_bcd  <= '0;
    end else if (start) begin
      cap   <= posit;
      nar_q <= nar_in;
      bin   <= fixed[FIXED_BITS-1:FRAC_BITS];
      frac  <= fixed[FRAC_BITS-1:0];
      bcd_w <= '0;
      bcd_f <= '0;
      step  <= '0;
      state <= CONV;
    end else if (state == CONV) begin
      if (step == 5'(DABBLE_STEPS)) begin
        whole_bcd <= nar_q ? '1 : bcd_w;
        frac_bcd  <= nar_q ? '1 : bcd_f;
        state     <= DONE;
      end else begin
        bin   <= bin << 1;
        bcd_w <= dabble_next;
        // Fraction digits run alongside the first ten dabble steps; truncated, not rounded.
        if (step < 5'(FRAC_STEPS)) begin
          frac  <= frac_prod[FRAC_BITS-1:0];
          bcd_f <= {bcd_f[W-5:0], frac_prod[FRAC_BITS+3:FRAC_BITS]};
        end
        step <= step + 5'd1;
      end
    end
  end

`ifdef DISPLAY_POSIT16_DONE_EN
  assign done = (state == DONE);
`endif

endmodule

// File: tb/tb_display_posit16.sv
// Self-checking bench for display_posit16: directed table, reset/hold sequences
// and random posits against an arithmetic reference model.
module tb_display_posit16;
  import posit16_pkg::*;

  logic        clock;
  logic        reset;
  logic [15:0] posit;
  logic [39:0] whole_bcd;
  logic [39:0] frac_bcd;
`ifdef DISPLAY_POSIT16_DONE_EN
  logic        done;
`endif

  logic        d_sign;
  regime_t     d_regime;
  logic        d_exp;
  logic [11:0] d_mant;
  logic [15:0] d_posit;

  int checks = 0;
  int errors = 0;

  logic [39:0] prev_w;
  logic [39:0] prev_f;

  typedef struct {
    logic [15:0] p;
    logic        s;
    int          k;
    logic        e;
    logic [11:0] m;
    logic [39:0] w;
    logic [39:0] f;
  } vec_t;

  vec_t tbl[9];

  display_posit16 dut (
    .clock     (clock),
    .reset     (reset),
    .posit     (posit),
    .whole_bcd (whole_bcd),
    .frac_bcd  (frac_bcd)
`ifdef DISPLAY_POSIT16_DONE_EN
    ,
    .done      (done)
`endif
  );

  decompose_posit u_dec (d_sign, d_regime, d_exp, d_mant, d_posit);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: value = (2^mbits + mant) * 2^(2k + e - mbits), digits by /10 and *10.
  function automatic void model(input logic [15:0] p, output logic [39:0] w, output logic [39:0] f);
    logic [15:0] mag;
    int          run, k, nrem, e, mbits;
    longint      rem, mval;
    logic [79:0] fx;
    logic [29:0] whole;
    logic [39:0] fr;
    logic [47:0] t;
    w = '0;
    f = '0;
    if (p == 16'h8000) begin
      w = '1;
      f = '1;
      return;
    end
    if (p == 16'h0000) return;
    mag = p[15] ? 16'(16'd0 - p) : p;
    run = 1;
    while (run < 15 && mag[14-run] == mag[14]) run++;
    k = mag[14] ? run - 1 : -run;
    nrem = 14 - run;
    if (nrem < 0) nrem = 0;
    rem = longint'(mag) & ((64'd1 << nrem) - 1);
    if (nrem > 0) begin
      e     = int'(rem >> (nrem - 1));
      mbits = nrem - 1;
      mval  = rem & ((64'd1 << mbits) - 1);
    end else begin
      e     = 0;
      mbits = 0;
      mval  = 0;
    end
    fx = 80'((64'd1 << mbits) + mval) << (2 * k + e - mbits + 40);
    whole = fx[69:40];
    fr    = fx[39:0];
    for (int i = 0; i < 10; i++) begin
      w[4*i +: 4] = 4'(whole % 10);
      whole = whole / 10;
    end
    for (int i = 0; i < 10; i++) begin
      t = 48'(fr) * 48'd10;
      f[39-4*i -: 4] = t[43:40];
      fr = t[39:0];
    end
  endfunction

  // Called at a negedge with the DUT about to capture on the next posedge.
  task automatic wait_check(input logic [39:0] ew, input logic [39:0] ef, input string tag);
    repeat (31) @(posedge clock);
    #1;
    check({tag, " hold whole"}, 64'(whole_bcd), 64'(prev_w));
    check({tag, " hold frac"}, 64'(frac_bcd), 64'(prev_f));
`ifdef DISPLAY_POSIT16_DONE_EN
    check({tag, " done low"}, 64'(done), 64'd0);
`endif
    @(posedge clock);
    #1;
    check({tag, " whole"}, 64'(whole_bcd), 64'(ew));
    check({tag, " frac"}, 64'(frac_bcd), 64'(ef));
`ifdef DISPLAY_POSIT16_DONE_EN
    check({tag, " done high"}, 64'(done), 64'd1);
`endif
    prev_w = ew;
    prev_f = ef;
    @(negedge clock);
  endtask

  task automatic convert(input logic [15:0] p, input logic [39:0] ew, input logic [39:0] ef, input string tag);
    posit = p;
    wait_check(ew, ef, tag);
  endtask

  initial begin
    logic [15:0] rp;
    logic [15:0] last_p;
    logic [39:0] mw;
    logic [39:0] mf;

    tbl[0] = '{16'h3000, 1'b0, -1,  1'b1, 12'h000, 40'h0000000000, 40'h5000000000};
    tbl[1] = '{16'h4800, 1'b0,  0,  1'b0, 12'h800, 40'h0000000001, 40'h5000000000};
    tbl[2] = '{16'h5922, 1'b0,  0,  1'b1, 12'h922, 40'h0000000003, 40'h1416015625};
    tbl[3] = '{16'h782c, 1'b0,  3,  1'b0, 12'h160, 40'h0000000069, 40'h5000000000};
    tbl[4] = '{16'h2cfd, 1'b0, -1,  1'b0, 12'hCFD, 40'h0000000000, 40'h4529418945};
    tbl[5] = '{16'hd305, 1'b1, -1,  1'b0, 12'hCFB, 40'h0000000000, 40'h4528198242};
    tbl[6] = '{16'h7fff, 1'b0, 14,  1'b0, 12'h000, 40'h0268435456, 40'h0000000000};
    tbl[7] = '{16'h8000, 1'b1,  0,  1'b0, 12'h000, 40'hFFFFFFFFFF, 40'hFFFFFFFFFF};
    tbl[8] = '{16'h0000, 1'b0,  0,  1'b0, 12'h000, 40'h0000000000, 40'h0000000000};

    reset   = 1'b0;
    posit   = 16'h0000;
    d_posit = 16'h0000;
    prev_w  = '0;
    prev_f  = '0;

    // Standalone field extractor
    for (int i = 0; i < 9; i++) begin
      d_posit = tbl[i].p;
      #1;
      check($sformatf("dec %h sign", tbl[i].p), 64'(d_sign), 64'(tbl[i].s));
      check($sformatf("dec %h k", tbl[i].p), 64'($signed(d_regime)), 64'(tbl[i].k));
      check($sformatf("dec %h exp", tbl[i].p), 64'(d_exp), 64'(tbl[i].e));
      check($sformatf("dec %h mant", tbl[i].p), 64'(d_mant), 64'(tbl[i].m));
    end

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset whole", 64'(whole_bcd), 64'd0);
    check("reset frac", 64'(frac_bcd), 64'd0);
`ifdef DISPLAY_POSIT16_DONE_EN
    check("reset done", 64'(done), 64'd0);
`endif

    // First conversion straight out of reset, then the rest of the table
    posit = tbl[0].p;
    reset = 1'b1;
    wait_check(tbl[0].w, tbl[0].f, "vec 3000");
    for (int i = 1; i < 9; i++) begin
      convert(tbl[i].p, tbl[i].w, tbl[i].f, $sformatf("vec %h", tbl[i].p));
    end

    // Outputs hold in DONE while the input is stable
    convert(16'h5922, tbl[2].w, tbl[2].f, "pre hold");
    repeat (40) @(posedge clock);
    #1;
    check("hold whole", 64'(whole_bcd), 64'(tbl[2].w));
    check("hold frac", 64'(frac_bcd), 64'(tbl[2].f));

    // Reset mid-conversion clears at once, then conversion restarts on release
    @(negedge clock);
    posit = 16'h782c;
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("midreset whole", 64'(whole_bcd), 64'd0);
    check("midreset frac", 64'(frac_bcd), 64'd0);
    @(negedge clock);
    prev_w = '0;
    prev_f = '0;
    reset  = 1'b1;
    wait_check(tbl[3].w, tbl[3].f, "after reset");

    // Random posits against the model
    last_p = 16'h782c;
    for (int n = 0; n < 40; n++) begin
      rp = 16'($urandom);
      if (rp == last_p) rp = rp ^ 16'h0001;
      model(rp, mw, mf);
      convert(rp, mw, mf, $sformatf("rand %h", rp));
      last_p = rp;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_posit16.md
Name: display_posit16

Overview:
- Converts a 16-bit posit (es=1) into a fixed-point decimal readout: 10 BCD digits of integer part and 10 BCD digits of fractional part, magnitude only.
- A combinational sub-module, decompose_posit, extracts sign, regime, exponent and mantissa.
- Sits between posit arithmetic and display/debug logic. The sign is taken separately from decompose_posit.

Parameters:
- POSIT_NBITS, 16, posit width; only 16 is supported.
- POSIT_ES, 1, exponent field width; only 1 is supported (useed = 4).
- BCD_DIGITS, 10, digits in each of whole_bcd and frac_bcd.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- posit  in  16  posit pattern to convert.
- whole_bcd  out  40  integer part, 10 packed BCD digits, MSD in [39:36].
- frac_bcd  out  40  fraction part, 10 packed BCD digits, first digit after the point in [39:36].

Behaviour:
- **decompose_posit** (combinational; positional ports sign, regime[4:0], exponent, mantissa[11:0], posit[15:0]):
  - sign = posit[15].
  - If sign is 1, the body is taken from the two's complement of posit.
  - regime is signed k. A run of m ones gives k = m-1; a run of m zeros gives k = -m. A run ending at the LSB with no terminator is allowed.
  - Range of k is -14..14.
  - exponent is the next bit after the terminator; 0 if absent.
  - mantissa is the remaining bits, left-aligned (bit 11 has weight 1/2), zero-padded.
  - 0x0000 and 0x8000 (NaR) give sign per bit 15, regime 0, exponent 0, mantissa 0.
- **Magnitude**: (4096+mantissa) * 2^(2k+exponent-12), formed as a 30-bit whole part and a 40-bit binary fraction. The maximum whole value is 2^28.
- **Reset (low)**: outputs and all state clear to 0; FSM goes to IDLE.
- **FSM**:
  - IDLE: on the first rising edge with reset high, capture posit, compute the fixed-point value, and go to CONV.
  - CONV: whole part uses 30-step shift-add-3 double-dabble. Fraction part, concurrently, runs 10 steps of multiply-by-10, emitting the integer carry digit each step; the fraction is truncated, not rounded.
  - After step 30, go to DONE and load whole_bcd/frac_bcd atomically. Total latency is 32 rising edges from capture.
  - DONE: outputs hold. If posit differs from the captured value, restart at capture on the next edge.
- Outputs change only at the DONE load or at reset; intermediate results are never visible.
- Special inputs:
  - 0x0000 gives all-zero outputs.
  - NaR (0x8000) gives both outputs = 40'hFFFFFFFFFF.
- A negative posit displays its magnitude.
- Reset asserted mid-conversion aborts immediately and clears the outputs.

Optional Feature:
- Macro: DISPLAY_POSIT16_DONE_EN.
- When defined: adds output port done (1 bit). It is 0 on reset and during IDLE/CONV, and 1 in DONE, the same edge the outputs load.
- When undefined: no done port; behaviour is otherwise identical.

Decomposition:
- Package posit16_pkg holds:
  - constants POSIT_NBITS=16, POSIT_ES=1, MANT_BITS=12, BCD_DIGITS=10, NAR_PATTERN=16'h8000;
  - FSM state enum {IDLE, CONV, DONE};
  - the regime type (signed 5-bit).
- Sub-module decompose_posit (combinational field extractor) is instantiated inside display_posit16 and is also usable standalone.

Test Plan:
- 16'h3000 -> decompose: s=0, k=-1, e=1, m=0; after 32 cycles whole=0000000000, frac=5000000000.
- 16'h4800 -> k=0, e=0, m=0x800; whole=0000000001, frac=5000000000.
- 16'h5922 -> k=0, e=1, m=0x922; whole=0000000003, frac=1416015625.
- 16'h782c -> k=3, e=0, m=0x160; whole=0000000069, frac=5000000000.
- 16'h2cfd -> k=-1, e=0, m=0xCFD; whole=0, frac=4529418945. Then 16'hd305 -> s=1, magnitude 0x2cfb, frac=4528198242.
- 16'h7fff -> whole=0268435456, frac=0. 16'h8000 -> all F. Reset low mid-conversion -> outputs 0 immediately, and conversion restarts after release.
